hazard_unit: RTL and testbench

//  Control end of the stage pipeline registers: generates stall/flush for the F/D, D/E and E/M

---
 rtl/hazard_if.sv | 33 +++
 rtl/hazard_unit.sv | 128 ++++++++++++
 tb/tb_hazard_unit.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/hazard_if.sv
// Signal bundle between the pipeline control logic and the hazard unit.
// No valid/ready handshake here: every signal is level-sensitive and is sampled in the cycle it is presented.
interface hazard_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       Rs1_D, Rs2_D;
    logic [4:0]       Rs1_E, Rs2_E;
    logic [4:0]       Rd_E, Rd_M, Rd_W;
    logic             RegWrite_M, RegWrite_W;
    logic [1:0]       ResultSrc_E;
    logic             PCSrc_E;
    logic             MultiCycle_E;
    logic             Stall_F, Stall_D, Flush_D;
    logic             Stall_E, Flush_E, Bubble_M;
    logic [1:0]       ForwardA_E, ForwardB_E;
    logic             MC_Done;
    logic [CNT_W-1:0] StallCycles, FlushEvents;
    logic             state_dbg;

    modport master (
        output Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W,
               RegWrite_M, RegWrite_W, ResultSrc_E, PCSrc_E, MultiCycle_E,
        input  Stall_F, Stall_D, Flush_D, Stall_E, Flush_E, Bubble_M,
               ForwardA_E, ForwardB_E, MC_Done, StallCycles, FlushEvents, state_dbg
    );

    modport slave (
        input  Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W,
               RegWrite_M, RegWrite_W, ResultSrc_E, PCSrc_E, MultiCycle_E,
        output Stall_F, Stall_D, Flush_D, Stall_E, Flush_E, Bubble_M,
               ForwardA_E, ForwardB_E, MC_Done, StallCycles, FlushEvents, state_dbg
    );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard control: operand forwarding, load-use/branch stall and flush,
// multi-cycle execute sequencing and saturating stall/flush counters.
module hazard_unit #(
    parameter int MC_LATENCY = 4,
    parameter int CNT_W      = 32
) (
    input logic   clk,
    input logic   rst,
    hazard_if.slave hif
);
    localparam int CW = (MC_LATENCY > 2) ? $clog2(MC_LATENCY) : 1;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t           state, state_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic [CNT_W-1:0] stall_cycles, flush_events;

    logic stall_f, stall_d, flush_d, stall_e, flush_e, bubble_m, mc_done;
    logic lw_stall;
    logic [1:0] fwd_a, fwd_b;

    // Forwarding: the younger result in M beats the older one in W.
    always_comb begin
        fwd_a = 2'b00;
        if (hif.RegWrite_M && hif.Rd_M != 5'd0 && hif.Rd_M == hif.Rs1_E)
            fwd_a = 2'b10;
        else if (hif.RegWrite_W && hif.Rd_W != 5'd0 && hif.Rd_W == hif.Rs1_E)
            fwd_a = 2'b01;
    end

    always_comb begin
        fwd_b = 2'b00;
        if (hif.RegWrite_M && hif.Rd_M != 5'd0 && hif.Rd_M == hif.Rs2_E)
            fwd_b = 2'b10;
        else if (hif.RegWrite_W && hif.Rd_W != 5'd0 && hif.Rd_W == hif.Rs2_E)
            fwd_b = 2'b01;
    end

    // A taken branch squashes the dependent instruction, so no load-use stall then.
    assign lw_stall = (hif.ResultSrc_E == 2'b01) && (hif.Rd_E != 5'd0) &&
                      ((hif.Rd_E == hif.Rs1_D) || (hif.Rd_E == hif.Rs2_D)) &&
                      !hif.PCSrc_E;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // While reset is held every control output stays low, so an aborted op never raises MC_Done.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        stall_f    = 1'b0;
        stall_d    = 1'b0;
        flush_d    = 1'b0;
        stall_e    = 1'b0;
        flush_e    = 1'b0;
        bubble_m   = 1'b0;
        mc_done    = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (hif.MultiCycle_E) begin
                        if (MC_LATENCY == 1) begin
                            mc_done = 1'b1;
                        end else begin
                            stall_f    = 1'b1;
                            stall_d    = 1'b1;
                            stall_e    = 1'b1;
                            bubble_m   = 1'b1;
                            state_next = BUSY;
                            cnt_next   = CW'(MC_LATENCY - 2);
                        end
                    end else begin
                        stall_f = lw_stall;
                        stall_d = lw_stall;
                        flush_e = lw_stall | hif.PCSrc_E;
                        flush_d = hif.PCSrc_E;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        stall_f  = 1'b1;
                        stall_d  = 1'b1;
                        stall_e  = 1'b1;
                        bubble_m = 1'b1;
                        cnt_next = cnt - 1'b1;
                    end else begin
                        mc_done    = 1'b1;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (stall_f && stall_cycles != '1)
                stall_cycles <= stall_cycles + 1'b1;
            if (hif.PCSrc_E && flush_events != '1)
                flush_events <= flush_events + 1'b1;
        end
    end

    assign hif.Stall_F     = stall_f;
    assign hif.Stall_D     = stall_d;
    assign hif.Flush_D     = flush_d;
    assign hif.Stall_E     = stall_e;
    assign hif.Flush_E     = flush_e;
    assign hif.Bubble_M    = bubble_m;
    assign hif.ForwardA_E  = fwd_a;
    assign hif.ForwardB_E  = fwd_b;
    assign hif.MC_Done     = mc_done;
    assign hif.StallCycles = stall_cycles;
    assign hif.FlushEvents = flush_events;
    assign hif.state_dbg   = state;
endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit with MC_LATENCY=4 and 4-bit counters.
module tb_hazard_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    hazard_if #(.CNT_W(4)) hif ();

    hazard_unit #(.MC_LATENCY(4), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .hif (hif.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        hif.Rs1_D = 5'd0; hif.Rs2_D = 5'd0; hif.Rs1_E = 5'd0; hif.Rs2_E = 5'd0;
        hif.Rd_E = 5'd0; hif.Rd_M = 5'd0; hif.Rd_W = 5'd0;
        hif.RegWrite_M = 1'b0; hif.RegWrite_W = 1'b0;
        hif.ResultSrc_E = 2'b00; hif.PCSrc_E = 1'b0; hif.MultiCycle_E = 1'b0;
    endtask

    // Packs the six stall/flush outputs plus MC_Done as {Stall_F,Stall_D,Flush_D,Stall_E,Flush_E,Bubble_M,MC_Done}.
    function automatic logic [31:0] ctl();
        return {25'd0, hif.Stall_F, hif.Stall_D, hif.Flush_D, hif.Stall_E,
                hif.Flush_E, hif.Bubble_M, hif.MC_Done};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("reset_ctl", ctl(), 32'h00);
        check("reset_fwd", {hif.ForwardA_E, hif.ForwardB_E}, 32'h0);
        check("reset_stallcnt", hif.StallCycles, 32'h0);
        check("reset_flushcnt", hif.FlushEvents, 32'h0);
        check("reset_state", hif.state_dbg, 32'h0);

        // Forwarding priority
        hif.RegWrite_M = 1'b1; hif.Rd_M = 5'd5;
        hif.RegWrite_W = 1'b1; hif.Rd_W = 5'd5;
        hif.Rs1_E = 5'd5;
        #1;
        check("fwdA_m_wins", hif.ForwardA_E, 32'h2);
        check("fwdB_none", hif.ForwardB_E, 32'h0);
        hif.Rd_M = 5'd0;
        #1;
        check("fwdA_rdm0_w", hif.ForwardA_E, 32'h1);
        hif.Rs2_E = 5'd5; hif.RegWrite_W = 1'b0;
        #1;
        check("fwdA_none", hif.ForwardA_E, 32'h0);
        hif.Rd_M = 5'd5; hif.RegWrite_M = 1'b0; hif.RegWrite_W = 1'b1;
        #1;
        check("fwdB_w", hif.ForwardB_E, 32'h1);
        hif.Rd_W = 5'd0; hif.Rs1_E = 5'd0; hif.Rs2_E = 5'd0;
        #1;
        check("fwd_r0_never", {hif.ForwardA_E, hif.ForwardB_E}, 32'h0);
        idle_inputs();

        // Load-use stall for one cycle
        hif.ResultSrc_E = 2'b01; hif.Rd_E = 5'd3; hif.Rs2_D = 5'd3;
        #1;
        check("lw_ctl", ctl(), 32'b1100100);
        tick();
        idle_inputs();
        check("lw_stallcnt", hif.StallCycles, 32'h1);
        check("lw_flushcnt", hif.FlushEvents, 32'h0);

        // Load with Rd_E=0 never stalls
        hif.ResultSrc_E = 2'b01; hif.Rd_E = 5'd0; hif.Rs1_D = 5'd0;
        #1;
        check("lw_r0_ctl", ctl(), 32'h00);
        idle_inputs();

        // Branch beats load-use
        hif.ResultSrc_E = 2'b01; hif.Rd_E = 5'd3; hif.Rs2_D = 5'd3; hif.PCSrc_E = 1'b1;
        #1;
        check("br_ctl", ctl(), 32'b0010100);
        tick();
        idle_inputs();
        check("br_flushcnt", hif.FlushEvents, 32'h1);
        check("br_stallcnt", hif.StallCycles, 32'h1);

        // Multi-cycle op: three stall cycles then MC_Done
        hif.MultiCycle_E = 1'b1;
        #1;
        check("mc_c1", ctl(), 32'b1101010);
        tick();
        check("mc_c2_state", hif.state_dbg, 32'h1);
        check("mc_c2", ctl(), 32'b1101010);
        tick();
        check("mc_c3", ctl(), 32'b1101010);
        tick();
        check("mc_c4_done", ctl(), 32'b0000001);
        tick();
        hif.MultiCycle_E = 1'b0;
        #1;
        check("mc_after_state", hif.state_dbg, 32'h0);
        check("mc_after_ctl", ctl(), 32'h00);
        check("mc_stallcnt", hif.StallCycles, 32'h4);

        // Reset during the second BUSY cycle aborts the op
        hif.MultiCycle_E = 1'b1;
        tick();
        tick();
        check("rst_mid_state", hif.state_dbg, 32'h1);
        rst = 1'b1;
        hif.MultiCycle_E = 1'b0;
        #1;
        check("rst_mid_ctl", ctl(), 32'h00);
        tick();
        rst = 1'b0;
        #1;
        check("rst_after_state", hif.state_dbg, 32'h0);
        check("rst_after_ctl", ctl(), 32'h00);
        check("rst_after_stallcnt", hif.StallCycles, 32'h0);
        check("rst_after_flushcnt", hif.FlushEvents, 32'h0);

        // Long load-use run saturates StallCycles
        hif.ResultSrc_E = 2'b01; hif.Rd_E = 5'd7; hif.Rs1_D = 5'd7;
        for (int i = 0; i < 14; i++) tick();
        check("sat_14", hif.StallCycles, 32'hE);
        tick();
        check("sat_15", hif.StallCycles, 32'hF);
        for (int i = 0; i < 5; i++) tick();
        check("sat_hold", hif.StallCycles, 32'hF);
        idle_inputs();

        // Long branch run saturates FlushEvents
        hif.PCSrc_E = 1'b1;
        for (int i = 0; i < 17; i++) tick();
        check("flush_sat", hif.FlushEvents, 32'hF);
        check("flush_sat_stall_hold", hif.StallCycles, 32'hF);
        idle_inputs();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
